memory_game_ctrl: RTL

Game controller for the card-flip memory game. It turns single-cycle button pulses into the `card_states` and `cursor_pos` values that drive `vga_display`. It tracks face-up, matched and selected cards, judges pairs against a fixed symbol layout, holds mismatched pairs visible for a programmable time, and counts moves. It sits between the button debouncers and `vga_display`.

---
 rtl/memory_game_pkg.sv | 15 +
 rtl/game_hold_timer.sv | 45 ++++
 rtl/memory_game_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/memory_game_pkg.sv
// Shared types and widths for the card-flip memory game controller.
package memory_game_pkg;

  localparam int unsigned CURSOR_W = 4;
  localparam int unsigned MOVES_W  = 8;

  typedef enum logic [2:0] {
    StIdle,
    StOneUp,
    StCheck,
    StHold,
    StWon
  } game_state_t;

endpackage

// File: rtl/game_hold_timer.sv
// Load/decrement down-counter that keeps a mismatched pair visible.
// done is high while the timer is active and has reached zero.
module game_hold_timer #(
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam int unsigned CntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CntW-1:0] LoadVal = CntW'(HOLD_CYCLES - 1);

  logic [CntW-1:0] count_d, count_q;
  logic            active_d, active_q;

  always_comb begin
    count_d  = count_q;
    active_d = active_q;
    if (load) begin
      count_d  = LoadVal;
      active_d = 1'b1;
    end else if (active_q) begin
      if (count_q == '0) begin
        active_d = 1'b0;
      end else begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      active_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      active_q <= active_d;
    end
  end

  assign done = active_q && (count_q == '0);

endmodule

// File: rtl/memory_game_ctrl.sv
// Card-flip memory game controller: cursor, flip/match tracking, pair judging,
// mismatch hold timing and move counting for vga_display.
module memory_game_ctrl
  import memory_game_pkg::*;
#(
  parameter int unsigned                 NUM_CARDS   = 4,
  parameter int unsigned                 SYM_W       = 2,
  parameter logic [NUM_CARDS*SYM_W-1:0]  LAYOUT      = 8'h44,
  parameter int unsigned                 HOLD_CYCLES = 50_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 btn_select,
  output logic [NUM_CARDS-1:0] card_states,
  output logic [CURSOR_W-1:0]  cursor_pos,
  output logic [NUM_CARDS-1:0] matched,
  output logic [MOVES_W-1:0]   moves,
  output logic                 busy,
  output logic                 game_won
);

  localparam logic [CURSOR_W-1:0] LastIdx = CURSOR_W'(NUM_CARDS - 1);

  game_state_t state_d, state_q;

  logic [NUM_CARDS-1:0] flipped_d, flipped_q;
  logic [NUM_CARDS-1:0] matched_d, matched_q;
  logic [NUM_CARDS-1:0] card_states_d, card_states_q;
  logic [CURSOR_W-1:0]  first_d, first_q;
  logic [CURSOR_W-1:0]  second_d, second_q;
  logic [CURSOR_W-1:0]  cursor_d, cursor_q;
  logic [MOVES_W-1:0]   moves_d, moves_q;

  logic [NUM_CARDS-1:0] cur_oh, first_oh, second_oh;
  logic [SYM_W-1:0]     sym_first, sym_second;
  logic                 face_down_sel, pair_match, all_matched;
  logic                 accept_first, accept_second;
  logic                 hold_load, hold_done;

  always_comb begin
    cur_oh     = '0;
    first_oh   = '0;
    second_oh  = '0;
    sym_first  = '0;
    sym_second = '0;
    for (int i = 0; i < NUM_CARDS; i++) begin
      cur_oh[i]    = (cursor_q == CURSOR_W'(i));
      first_oh[i]  = (first_q == CURSOR_W'(i));
      second_oh[i] = (second_q == CURSOR_W'(i));
      if (first_q == CURSOR_W'(i))  sym_first  = LAYOUT[SYM_W*i +: SYM_W];
      if (second_q == CURSOR_W'(i)) sym_second = LAYOUT[SYM_W*i +: SYM_W];
    end
    face_down_sel = |(cur_oh & ~(flipped_q | matched_q));
    pair_match    = (sym_first == sym_second);
    all_matched   = &(matched_q | first_oh | second_oh);
    accept_first  = (state_q == StIdle) && btn_select && face_down_sel;
    accept_second = (state_q == StOneUp) && btn_select && face_down_sel &&
                    (cursor_q != first_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept_first) state_d = StOneUp;
      StOneUp: if (accept_second) state_d = StCheck;
      StCheck: begin
        if (pair_match) state_d = all_matched ? StWon : StIdle;
        else            state_d = StHold;
      end
      StHold:  if (hold_done) state_d = StIdle;
      StWon:   if (btn_select) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    flipped_d = flipped_q;
    matched_d = matched_q;
    first_d   = first_q;
    second_d  = second_q;
    moves_d   = moves_q;
    cursor_d  = cursor_q;

    if (accept_first) begin
      flipped_d = flipped_q | cur_oh;
      first_d   = cursor_q;
    end
    if (accept_second) begin
      flipped_d = flipped_q | cur_oh;
      second_d  = cursor_q;
      if (moves_q != '1) moves_d = moves_q + MOVES_W'(1);
    end
    if ((state_q == StCheck) && pair_match) begin
      matched_d = matched_q | first_oh | second_oh;
      flipped_d = '0;
    end
    if ((state_q == StHold) && hold_done) begin
      flipped_d = flipped_q & ~(first_oh | second_oh);
    end

    // Select acts on the pre-move cursor; the move still lands on the same edge.
    if ((state_q != StWon) && (btn_left ^ btn_right)) begin
      if (btn_left) cursor_d = (cursor_q == '0) ? LastIdx : cursor_q - CURSOR_W'(1);
      else          cursor_d = (cursor_q == LastIdx) ? '0 : cursor_q + CURSOR_W'(1);
    end

    if ((state_q == StWon) && btn_select) begin
      flipped_d = '0;
      matched_d = '0;
      moves_d   = '0;
      cursor_d  = '0;
    end

    card_states_d = flipped_d | matched_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flipped_q     <= '0;
      matched_q     <= '0;
      card_states_q <= '0;
      first_q       <= '0;
      second_q      <= '0;
      cursor_q      <= '0;
      moves_q       <= '0;
    end else begin
      flipped_q     <= flipped_d;
      matched_q     <= matched_d;
      card_states_q <= card_states_d;
      first_q       <= first_d;
      second_q      <= second_d;
      cursor_q      <= cursor_d;
      moves_q       <= moves_d;
    end
  end

  assign hold_load = (state_q == StCheck) && !pair_match;

  game_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk  (clk),
    .reset(reset),
    .load (hold_load),
    .done (hold_done)
  );

  always_comb begin
    busy        = (state_q == StCheck) || (state_q == StHold);
    game_won    = (state_q == StWon);
    card_states = card_states_q;
    cursor_pos  = cursor_q;
    matched     = matched_q;
    moves       = moves_q;
  end

endmodule
